cv32e40s_obi_instr_responder: RTL
=================================

# cv32e40s_obi_instr_responder

Simulation-only OBI instruction-side responder (subordinate) for the cv32e40s bhv/ benches. Answers the core's instruction fetch OBI initiator with grants and in-order read responses from a backdoor-loadable word memory. Grant stalls, per-transaction response latency and error responses are controllable, so the fetch path and RVFI instruction tracking can be stressed with up to DEPTH outstanding transactions. Initiator-side OBI protocol violations are flagged.

## Interface
- DEPTH, 4: max outstanding transactions; power of 2, ≥2
- MEM_WORDS, 256: memory size in 32-bit words; power of 2
- MEM_BASE, 32'h0000_0000: byte address of word 0; MEM_WORDS-aligned
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset: one clock; reset is synchronous and active-high
- req_i  in  1  OBI address phase request
- addr_i  in  32  OBI byte address
- gnt_o  out  1  OBI grant (combinational)
- rvalid_o  out  1  OBI response valid (registered state)
- rdata_o  out  32  response data; 0 when rvalid_o=0 or err_o=1
- err_o  out  1  response error; 0 when rvalid_o=0
- gnt_stall_i  in  1  bench forces gnt_o=0 this cycle
- rvalid_delay_i  in  2  extra response latency (0..3) sampled at grant
- err_en_i  in  1  enable forced-error address match
- err_addr_i  in  32  word address forced to respond err=1
- mem_we_i  in  1  backdoor write enable
- mem_waddr_i  in  $clog2(MEM_WORDS)  backdoor word index
- mem_wdata_i  in  32  backdoor write data
- outstanding_o  out  $clog2(DEPTH)+1  accepted, not yet responded
- protocol_err_o  out  1  sticky initiator violation flag

## Operation
- gnt_o = req_i && !rst && !gnt_stall_i && (outstanding_o < DEPTH); no bypass: a response popping in the same cycle does not free a slot for that cycle's grant.
- On req_i && gnt_o: push entry {word index, err, delay=rvalid_delay_i} into response FIFO; outstanding +1.
- err set at grant if addr_i[1:0]≠0, or (addr_i−MEM_BASE)>>2 ≥ MEM_WORDS (unsigned, wrap counts as out of range), or err_en_i && addr_i[31:2]==err_addr_i[31:2].
- Head entry: delay counter decrements each cycle while nonzero; when zero, rvalid_o=1 for exactly one cycle, then pop; outstanding −1. Simultaneous push/pop leaves outstanding unchanged.
- Responses strictly in grant order; at most one rvalid per cycle; back-to-back rvalid allowed.
- rdata_o read from memory at response cycle (not at grant); backdoor write in the response cycle is not visible until next cycle.
- Memory not affected by reset; backdoor writes accepted during reset.
- protocol_err_o sets (sticky until rst) if, in a cycle following req_i && !gnt_o, req_i drops or addr_i changes, with no grant having occurred. gnt_stall_i stalls count as normal wait states.

## Timing
- Reset: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, outstanding_o=0, protocol_err_o=0; FIFO pointers 0; in-flight transactions discarded without response.
- Grant to rvalid_o: 1+rvalid_delay_i cycles when FIFO empty ahead of it; otherwise ≥ previous response +1 cycle plus own remaining delay (delay counts only while head).
- Pointers PTR_WIDTH=$clog2(DEPTH) bits, natural wrap; count PTR_WIDTH+1 bits, full at DEPTH, empty at 0.
- rst asserted mid-transaction: next cycle all outputs at reset values; no late rvalid.

## Structure
- Entry typedef obi_instr_resp_entry_t {addr word index, err, delay[1:0]} goes in cv32e40s_rvfi_pkg alongside existing RVFI OBI types.
- One sub-module natural: cv32e40s_obi_instr_resp_fifo (DEPTH-entry FIFO with head delay counter, push/pop/count); address decode, memory and protocol checker stay in the top.

## Test plan
- Backdoor mem[4]=32'hDEAD_BEEF; req addr 32'h10, delay 0 → gnt same cycle, rvalid next cycle, rdata 32'hDEAD_BEEF, err 0.
- Four grants, delays 3,0,0,1, no stall → rvalids in order at cycles 4,5,6,8 after first grant; 5th req ungranted while outstanding=4.
- addr 32'h400 (MEM_WORDS=256) and addr 32'h6 → both err_o=1, rdata_o=0.
- gnt_stall_i held 3 cycles with req stable → no protocol_err_o; addr changed while waiting → protocol_err_o=1 until rst.
- rst asserted with 2 outstanding → no rvalid afterward, outstanding_o=0, gnt_o=0 during rst.
- Full FIFO, head pops same cycle as new req → gnt_o=0 that cycle, granted next cycle.

Source files
------------

// File: rtl/cv32e40s_rvfi_pkg.sv
// Shared RVFI/OBI bench types.
// Holds the instruction-side response FIFO entry.
package cv32e40s_rvfi_pkg;

  localparam int OBI_IDX_W = 30;

  typedef struct packed {
    logic [OBI_IDX_W-1:0] idx;
    logic                 err;
    logic [1:0]           delay;
  } obi_instr_resp_entry_t;

endpackage

// File: rtl/cv32e40s_obi_instr_responder_if.sv
// OBI instruction-side bus bundle.
// master = fetch initiator, slave = responder.
interface cv32e40s_obi_instr_responder_if;

  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/cv32e40s_obi_instr_resp_fifo.sv
// In-order response FIFO for the OBI responder.
// Only the head entry's delay counts down.
module cv32e40s_obi_instr_resp_fifo
  import cv32e40s_rvfi_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  obi_instr_resp_entry_t push_entry,
  input  logic                  pop,
  output obi_instr_resp_entry_t head,
  output logic                  head_ready,
  output logic [PTR_W:0]        count,
  output logic                  full
);

  localparam logic [PTR_W:0] DEPTH_C =
    (PTR_W+1)'(DEPTH);

  obi_instr_resp_entry_t mem [DEPTH];

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W:0]   cnt;
  logic             empty;

  assign empty      = (cnt == '0);
  assign full       = (cnt == DEPTH_C);
  assign count      = cnt;
  assign head       = mem[rptr];
  assign head_ready = !empty && (head.delay == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;
    end
  end

  // Push never hits the head slot unless empty, so no conflict.
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= push_entry;
    if (!empty && (mem[rptr].delay != 2'd0))
      mem[rptr].delay <= mem[rptr].delay - 1'b1;
  end

endmodule

// File: rtl/cv32e40s_obi_instr_responder.sv
// Simulation OBI instruction responder: grants, in-order
// delayed responses, backdoor memory, initiator checker.
module cv32e40s_obi_instr_responder
  import cv32e40s_rvfi_pkg::*;
#(
  parameter  int          DEPTH     = 4,
  parameter  int          MEM_WORDS = 256,
  parameter  logic [31:0] MEM_BASE  = 32'h0000_0000,
  localparam int          PTR_W     = $clog2(DEPTH),
  localparam int          IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  cv32e40s_obi_instr_responder_if.slave obi,
  input  logic             gnt_stall_i,
  input  logic [1:0]       rvalid_delay_i,
  input  logic             err_en_i,
  input  logic [31:0]      err_addr_i,
  input  logic             mem_we_i,
  input  logic [IDX_W-1:0] mem_waddr_i,
  input  logic [31:0]      mem_wdata_i,
  output logic [PTR_W:0]   outstanding_o,
  output logic             protocol_err_o
);

  localparam logic [31:0] MEM_WORDS_U =
    32'(MEM_WORDS);

  logic [31:0] mem [MEM_WORDS];

  obi_instr_resp_entry_t push_entry;
  obi_instr_resp_entry_t head;

  logic        head_ready;
  logic        full;
  logic        gnt;
  logic        rvalid;
  logic [29:0] woff;
  logic        oob;
  logic        misal;
  logic        forced;
  logic        wait_q;
  logic [31:0] addr_q;
  logic        perr_q;
  logic        unused_bits;

  // Wrapped offsets land far above MEM_WORDS.
  assign woff   = obi.addr[31:2] - MEM_BASE[31:2];
  assign oob    = {2'b00, woff} >= MEM_WORDS_U;
  assign misal  = |obi.addr[1:0];
  assign forced = err_en_i &&
                  (obi.addr[31:2] == err_addr_i[31:2]);

  assign push_entry = '{
    idx:   woff,
    err:   misal || oob || forced,
    delay: rvalid_delay_i
  };

  assign gnt = obi.req && !rst && !gnt_stall_i && !full;
  assign rvalid = !rst && head_ready;

  assign obi.gnt    = gnt;
  assign obi.rvalid = rvalid;
  assign obi.err    = rvalid && head.err;
  assign obi.rdata  = (rvalid && !head.err) ?
                      mem[head.idx[IDX_W-1:0]] : '0;

  assign protocol_err_o = perr_q;

  assign unused_bits = ^{err_addr_i[1:0],
                         head.idx[OBI_IDX_W-1:IDX_W]};

  cv32e40s_obi_instr_resp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (gnt),
    .push_entry (push_entry),
    .pop        (rvalid),
    .head       (head),
    .head_ready (head_ready),
    .count      (outstanding_o),
    .full       (full)
  );

  always_ff @(posedge clk) begin
    if (mem_we_i)
      mem[mem_waddr_i] <= mem_wdata_i;
  end

  // An ungranted request must hold req and addr.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= 1'b0;
      addr_q <= '0;
      perr_q <= 1'b0;
    end else begin
      wait_q <= obi.req && !gnt;
      addr_q <= obi.addr;
      if (wait_q && (!obi.req || (obi.addr != addr_q)))
        perr_q <= 1'b1;
    end
  end

endmodule
